// File: rtl/axis_tag_demux.sv
// Splits one serialized AXI-stream into NUM_TAGS per-tag streams using the one-hot tuser tag.
// Each tag owns a 2-entry buffer; malformed tags are dropped, flagged and counted.
module axis_tag_demux #(
    parameter int NUM_TAGS   = 20,
    parameter int DATA_WIDTH = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [NUM_TAGS-1:0]            s_axis_tuser,
    output logic [NUM_TAGS-1:0]            m_axis_tvalid,
    input  logic [NUM_TAGS-1:0]            m_axis_tready,
    output logic [NUM_TAGS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           err_tag,
    output logic [15:0]                    drop_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam logic [NUM_TAGS-1:0] TAG_ONE = NUM_TAGS'(1);

    logic                tag_ok;
    logic                target_full;
    logic                accept;
    logic [NUM_TAGS-1:0] full;

    // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        tag_ok        = 1'b0;
        target_full   = 1'b0;
        s_axis_tready = 1'b0;
        tag_ok        = (s_axis_tuser != '0) && ((s_axis_tuser & (s_axis_tuser - TAG_ONE)) == '0);
        // With a one-hot tag this selects exactly the target's full flag.
        target_full   = |(s_axis_tuser & full);
        s_axis_tready = !rst && (!tag_ok || !target_full);
    end

    assign accept = s_axis_tvalid && s_axis_tready;

    for (genvar j = 0; j < NUM_TAGS; j++) begin : g_tag
        occ_e                  occ;
        logic [DATA_WIDTH-1:0] head;
        logic [DATA_WIDTH-1:0] skid;
        logic                  push;
        logic                  pop;

        assign push = accept && tag_ok && s_axis_tuser[j];
        assign pop  = (occ != OCC_EMPTY) && m_axis_tready[j];

        // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                occ  <= OCC_EMPTY;
                head <= '0;
            end else begin
                case (occ)
                    OCC_EMPTY: begin
                        if (push) begin
                            head <= s_axis_tdata;
                            occ  <= OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (push && pop) begin
                            head <= s_axis_tdata;
                        end else if (push) begin
                            skid <= s_axis_tdata;
                            occ  <= OCC_TWO;
                        end else if (pop) begin
                            occ <= OCC_EMPTY;
                        end
                    end
                    OCC_TWO: begin
                        // A push is already refused by s_axis_tready at this occupancy.
                        if (pop) begin
                            head <= skid;
                            occ  <= OCC_ONE;
                        end
                    end
                    default: occ <= OCC_EMPTY;
                endcase
            end
        end
        // NOTE: skid is storage only read while occupancy is 2, so it is deliberately left out of reset.

        assign full[j]                                   = (occ == OCC_TWO);
        assign m_axis_tvalid[j]                          = (occ != OCC_EMPTY);
        assign m_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH]  = head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tag    <= 1'b0;
            drop_count <= '0;
        end else begin
            err_tag <= accept && !tag_ok;
            if (accept && !tag_ok && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
